// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped, read-only instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MEM_FETCH = 2'd1,
    UPDATE    = 2'd2
  } state_t;

  localparam int unsigned BLOCK_W    = 128;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned DEF_ADDR_W = 10;
  localparam int unsigned DEF_IDX_W  = 3;

endpackage

// File: rtl/icache_word_sel.sv
// Selects one 32-bit instruction word out of a 128-bit cache block.
module icache_word_sel
  import icache_pkg::*;
(
  input  logic [BLOCK_W-1:0] block,
  input  logic [1:0]         offset,
  output logic [WORD_W-1:0]  word
);

  always_comb begin
    word = block[31:0];
    case (offset)
      2'd0: word = block[31:0];
      2'd1: word = block[63:32];
      2'd2: word = block[95:64];
      2'd3: word = block[127:96];
      default: word = block[31:0];
    endcase
  end

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: combinational hit path, three-state
// refill FSM (IDLE -> MEM_FETCH -> UPDATE) fetching whole 16-byte blocks.
module icache
  import icache_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned IDX_W  = DEF_IDX_W
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [ADDR_W-1:0]   ADDRESS,
  input  logic                READ,
  output logic [WORD_W-1:0]   READDATA,
  output logic                BUSYWAIT,
  output logic [ADDR_W-5:0]   MEM_ADDRESS,
  output logic                MEM_READ,
  input  logic [BLOCK_W-1:0]  MEM_READDATA,
  input  logic                MEM_BUSYWAIT
);

  localparam int unsigned TAG_W = ADDR_W - 4 - IDX_W;
  localparam int unsigned NBLK  = 1 << IDX_W;

  state_t state_q, state_d;

  logic [BLOCK_W-1:0] data_q [NBLK];
  logic [TAG_W-1:0]   tag_q  [NBLK];
  logic [NBLK-1:0]    valid_q;
  logic [TAG_W-1:0]   miss_tag_q;
  logic [IDX_W-1:0]   miss_idx_q;
  logic [BLOCK_W-1:0] fill_q;

  logic [TAG_W-1:0]   addr_tag;
  logic [IDX_W-1:0]   addr_idx;
  logic [1:0]         addr_off;
  logic               hit;
  logic               miss_start;
  logic [WORD_W-1:0]  sel_word;
  logic               unused_byte_bits;

  assign addr_tag         = ADDRESS[ADDR_W-1 -: TAG_W];
  assign addr_idx         = ADDRESS[3+IDX_W:4];
  assign addr_off         = ADDRESS[3:2];
  assign unused_byte_bits = ^ADDRESS[1:0];

  assign hit        = READ && valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);
  assign miss_start = (state_q == IDLE) && READ && !hit;

  icache_word_sel u_word_sel (
    .block  (data_q[addr_idx]),
    .offset (addr_off),
    .word   (sel_word)
  );

  // Gated so READDATA is a defined zero whenever no hit is being returned.
  assign READDATA = (RESET && hit && (state_q == IDLE)) ? sel_word : '0;

  always_comb begin
    state_d     = state_q;
    BUSYWAIT    = 1'b0;
    MEM_READ    = 1'b0;
    MEM_ADDRESS = '0;
    case (state_q)
      IDLE: begin
        if (READ && !hit) begin
          BUSYWAIT = RESET;
          state_d  = MEM_FETCH;
        end
      end
      MEM_FETCH: begin
        MEM_READ    = 1'b1;
        MEM_ADDRESS = {miss_tag_q, miss_idx_q};
        BUSYWAIT    = 1'b1;
        if (!MEM_BUSYWAIT) state_d = UPDATE;
      end
      UPDATE: begin
        BUSYWAIT = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      miss_tag_q <= '0;
      miss_idx_q <= '0;
    end else begin
      state_q <= state_d;
      if (miss_start) begin
        miss_tag_q <= addr_tag;
        miss_idx_q <= addr_idx;
      end
      if (state_q == UPDATE) valid_q[miss_idx_q] <= 1'b1;
    end
  end

  // Storage needs no reset: valid bits guard it, and an aborted refill never reaches UPDATE.
  always_ff @(posedge CLK) begin
    if ((state_q == MEM_FETCH) && !MEM_BUSYWAIT) fill_q <= MEM_READDATA;
    if (state_q == UPDATE) begin
      data_q[miss_idx_q] <= fill_q;
      tag_q[miss_idx_q]  <= miss_tag_q;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: directed accesses queue expected words and refill
// block addresses; monitors pop and compare when the DUT responds.
module tb_icache;

  logic         CLK = 1'b0;
  logic         RESET = 1'b0;
  logic [9:0]   ADDRESS = '0;
  logic         READ = 1'b0;
  logic [31:0]  READDATA;
  logic         BUSYWAIT;
  logic [5:0]   MEM_ADDRESS;
  logic         MEM_READ;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;

  int tests = 0;
  int fails = 0;
  logic [31:0] rsp_q [$];
  logic [5:0]  mem_q [$];
  int mem_cnt = 0;

  icache #(.ADDR_W(10), .IDX_W(3)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .ADDRESS      (ADDRESS),
    .READ         (READ),
    .READDATA     (READDATA),
    .BUSYWAIT     (BUSYWAIT),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_READ     (MEM_READ),
    .MEM_READDATA (MEM_READDATA),
    .MEM_BUSYWAIT (MEM_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  // Memory model: 5-cycle latency; word w of block b is 0xC0DE0000 | b<<4 | w.
  function automatic logic [127:0] mem_block(input logic [5:0] b);
    logic [31:0] base;
    base = 32'hC0DE0000 | ({26'd0, b} << 4);
    return {base | 32'd3, base | 32'd2, base | 32'd1, base};
  endfunction

  always @(posedge CLK) mem_cnt <= MEM_READ ? mem_cnt + 1 : 0;
  assign MEM_BUSYWAIT = MEM_READ && (mem_cnt < 4);
  assign MEM_READDATA = mem_block(MEM_ADDRESS);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (RESET && READ && !BUSYWAIT) begin
      if (rsp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL rsp_unexpected: got %h, expected no response at %0t", READDATA, $time);
      end else check("readdata", READDATA, rsp_q.pop_front());
    end
    if (MEM_READ && !MEM_BUSYWAIT) begin
      if (mem_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL refill_unexpected: got block %h, expected no refill at %0t", MEM_ADDRESS, $time);
      end else check("mem_address", MEM_ADDRESS, mem_q.pop_front());
    end
    if (!MEM_READ) check("mem_address_idle", MEM_ADDRESS, 32'd0);
  end

  task automatic wait_ready(output int n);
    n = 0;
    @(negedge CLK);
    while (BUSYWAIT && n < 60) begin
      n++;
      @(negedge CLK);
    end
    if (BUSYWAIT) begin
      tests++; fails++;
      $display("FAIL busywait_timeout: got BUSYWAIT=1 after %0d cycles, expected release", n);
    end
  endtask

  task automatic access(input logic [9:0] a, input logic [31:0] exp_data,
                        input int exp_stall, input int miss_blk);
    int n;
    @(posedge CLK); #1;
    ADDRESS = a;
    READ    = 1'b1;
    rsp_q.push_back(exp_data);
    if (miss_blk >= 0) mem_q.push_back(miss_blk[5:0]);
    wait_ready(n);
    check("stall_cycles", n, exp_stall);
    if (exp_stall == 0) check("hit_no_mem_read", {31'd0, MEM_READ}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    READ = 1'b1;
    ADDRESS = 10'h000;
    @(negedge CLK);
    check("reset_busywait", {31'd0, BUSYWAIT}, 32'd0);
    check("reset_readdata", READDATA, 32'd0);
    check("reset_mem_read", {31'd0, MEM_READ}, 32'd0);
    READ = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b1;

    // cold miss then sequential hits within the block
    access(10'h000, 32'hC0DE0000, 7, 8'h00);
    access(10'h004, 32'hC0DE0001, 0, -1);
    access(10'h008, 32'hC0DE0002, 0, -1);
    access(10'h00C, 32'hC0DE0003, 0, -1);

    // conflict eviction on index 0
    access(10'h080, 32'hC0DE0080, 7, 8'h08);
    access(10'h000, 32'hC0DE0000, 7, 8'h00);
    access(10'h080, 32'hC0DE0080, 7, 8'h08);

    // address change during refill: 0x00 line still completes, then 0x3F misses
    @(posedge CLK); #1;
    ADDRESS = 10'h000;
    rsp_q.push_back(32'hC0DE03F0);
    mem_q.push_back(6'h00);
    mem_q.push_back(6'h3F);
    repeat (3) @(posedge CLK);
    #1 ADDRESS = 10'h3F0;
    wait_ready(n);
    check("toggle_stall_cycles", n, 11);
    access(10'h000, 32'hC0DE0000, 0, -1);
    access(10'h3F4, 32'hC0DE03F1, 0, -1);

    // reset in the 3rd MEM_FETCH cycle aborts the refill
    @(posedge CLK); #1;
    ADDRESS = 10'h100;
    repeat (3) @(posedge CLK);
    #2 RESET = 1'b0;
    READ = 1'b0;
    #1;
    check("abort_mem_read", {31'd0, MEM_READ}, 32'd0);
    check("abort_busywait", {31'd0, BUSYWAIT}, 32'd0);
    check("abort_mem_address", MEM_ADDRESS, 32'd0);
    @(posedge CLK); #1;
    RESET = 1'b1;
    access(10'h000, 32'hC0DE0000, 7, 8'h00);
    access(10'h3F0, 32'hC0DE03F0, 7, 8'h3F);

    // idle with READ low
    @(posedge CLK); #1;
    READ = 1'b0;
    repeat (10) begin
      @(negedge CLK);
      check("idle_busywait", {31'd0, BUSYWAIT}, 32'd0);
      check("idle_mem_read", {31'd0, MEM_READ}, 32'd0);
    end
    access(10'h00C, 32'hC0DE0003, 0, -1);

    @(posedge CLK); #1;
    READ = 1'b0;
    @(negedge CLK);
    check("rsp_queue_empty", rsp_q.size(), 32'd0);
    check("mem_queue_empty", mem_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
